// File: rtl/mandelbrot_pkg.sv
// Shared constants and types for the mandelbrot frame datapath.
// Frame geometry defaults, reserved index and fp64 helpers.
package mandelbrot_pkg;

    localparam int          H_RES_DEFAULT = 320;
    localparam int          V_RES_DEFAULT = 240;
    localparam logic [16:0] IDX_NONE      = 17'h1FFFF;
    localparam logic [63:0] FP64_SIGN     = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT,
        ST_ADVANCE,
        ST_WAIT,
        ST_FINISH
    } ccg_state_t;

endpackage

// File: rtl/fp64_add_pipe.sv
// Pipelined IEEE-754 fp64 adder (round-to-nearest-even, subnormals kept; NaN/inf passed through from the larger operand).
// Latency LATENCY cycles, fully pipelined; no backpressure, every cycle accepts a new operand pair.
module fp64_add_pipe #(
    parameter int LATENCY = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        in_valid,
    output logic [63:0] sum,
    output logic        out_valid
);

    function automatic logic [63:0] fp64_add(input logic [63:0] op_a, input logic [63:0] op_b);
        logic [63:0] big;
        logic [63:0] sml;
        logic        eff_sub;
        int          e_big;
        int          e_sml;
        int          d;
        int          lz;
        int          e_res;
        logic [55:0] x;
        logic [55:0] y;
        logic [55:0] y_sh;
        logic [55:0] mask;
        logic [55:0] m;
        logic [56:0] s;
        logic [53:0] mant;
        logic        up;
        logic [63:0] res;

        if (op_a[62:0] >= op_b[62:0]) begin
            big = op_a;
            sml = op_b;
        end else begin
            big = op_b;
            sml = op_a;
        end
        eff_sub = big[63] ^ sml[63];
        e_big   = (big[62:52] == 11'd0) ? 1 : int'(big[62:52]);
        e_sml   = (sml[62:52] == 11'd0) ? 1 : int'(sml[62:52]);
        // three extra bits below the lsb: guard, round, sticky
        x = {(big[62:52] != 11'd0), big[51:0], 3'b000};
        y = {(sml[62:52] != 11'd0), sml[51:0], 3'b000};
        d = e_big - e_sml;
        if (d > 55) begin
            y_sh = {55'd0, |y};
        end else begin
            mask = (56'd1 << d) - 56'd1;
            y_sh = (y >> d) | {55'd0, |(y & mask)};
        end
        s = eff_sub ? ({1'b0, x} - {1'b0, y_sh}) : ({1'b0, x} + {1'b0, y_sh});

        lz = 56;
        for (int i = 0; i < 56; i++) begin
            if (s[i]) lz = 55 - i;
        end

        m     = '0;
        e_res = 0;
        mant  = '0;
        up    = 1'b0;
        if (big[62:52] == 11'h7FF) begin
            res = big;
        end else if (s == 57'd0) begin
            res = {~eff_sub & big[63], 63'd0};
        end else begin
            if (s[56]) begin
                m     = {s[56:2], s[1] | s[0]};
                e_res = e_big + 1;
            end else if (e_big - lz < 1) begin
                m     = s[55:0] << (e_big - 1);
                e_res = 0;
            end else begin
                m     = s[55:0] << lz;
                e_res = e_big - lz;
            end
            up   = m[2] & (m[1] | m[0] | m[3]);
            mant = {1'b0, m[55:3]} + {53'd0, up};
            if (mant[53]) begin
                mant  = mant >> 1;
                e_res = e_res + 1;
            end else if (e_res == 0 && mant[52]) begin
                e_res = 1;
            end
            if (e_res >= 2047) res = {big[63], 11'h7FF, 52'd0};
            else               res = {big[63], e_res[10:0], mant[51:0]};
        end
        return res;
    endfunction

    logic [63:0]        pipe_dat [LATENCY];
    logic [LATENCY-1:0] pipe_vld;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) pipe_dat[i] <= '0;
            pipe_vld <= '0;
        end else begin
            pipe_dat[0] <= fp64_add(a, b);
            pipe_vld[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_dat[i] <= pipe_dat[i-1];
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    assign sum       = pipe_dat[LATENCY-1];
    assign out_valid = pipe_vld[LATENCY-1];

endmodule

// File: rtl/cell_coordinate_generator.sv
// Raster walker feeding idx/x0/y0 into the rtc queues; one write per ADD_LATENCY+2 cycles.
// Latency: first write 2 cycles after start; backpressure: rtc_full holds in EMIT indefinitely, nothing lost.
module cell_coordinate_generator
    import mandelbrot_pkg::*;
#(
    parameter int H_RES       = H_RES_DEFAULT,
    parameter int V_RES       = V_RES_DEFAULT,
    parameter int IDX_WIDTH   = 17,
    parameter int ADD_LATENCY = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [63:0]          x_min,
    input  logic [63:0]          y_max,
    input  logic [63:0]          dx,
    input  logic [63:0]          dy,
    input  logic                 rtc_full,
    output logic                 rtc_write,
    output logic [IDX_WIDTH-1:0] idx_to_rtc,
    output logic [63:0]          x0_to_rtc,
    output logic [63:0]          y0_to_rtc,
    output logic                 busy,
    output logic                 done
);

    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int CNT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
    localparam logic [IDX_WIDTH-1:0] IDX_NONE_W = {IDX_WIDTH{1'b1}};

    ccg_state_t           state;
    ccg_state_t           state_nxt;
    logic [63:0]          x_min_q;
    logic [63:0]          dx_q;
    logic [63:0]          dy_q;
    logic [63:0]          cur_x;
    logic [63:0]          cur_y;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [IDX_WIDTH-1:0] idx;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 tgt_y;
    logic                 last_col;
    logic                 last_pix;
    logic                 wait_done;
    logic [63:0]          add_a;
    logic [63:0]          add_b;
    logic [63:0]          add_sum;
    logic                 add_in_vld;
    logic                 add_out_vld;

    assign last_col  = (col == COL_W'(H_RES - 1));
    assign last_pix  = last_col && (row == ROW_W'(V_RES - 1));
    assign wait_done = (wait_cnt == CNT_W'(ADD_LATENCY - 1));

    // Row wrap steps y downward by adding -dy; otherwise step x by dx.
    assign add_in_vld = (state == ST_ADVANCE);
    assign add_a      = last_col ? cur_y : cur_x;
    assign add_b      = last_col ? (dy_q ^ FP64_SIGN) : dx_q;

    fp64_add_pipe #(
        .LATENCY (ADD_LATENCY)
    ) u_add (
        .clock     (clock),
        .reset_n   (reset_n),
        .a         (add_a),
        .b         (add_b),
        .in_valid  (add_in_vld),
        .sum       (add_sum),
        .out_valid (add_out_vld)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_EMIT;
            ST_EMIT:    if (!rtc_full) state_nxt = last_pix ? ST_FINISH : ST_ADVANCE;
            ST_ADVANCE: state_nxt = ST_WAIT;
            ST_WAIT:    if (wait_done) state_nxt = ST_EMIT;
            ST_FINISH:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_min_q    <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            col        <= '0;
            row        <= '0;
            idx        <= '0;
            wait_cnt   <= '0;
            tgt_y      <= 1'b0;
            rtc_write  <= 1'b0;
            idx_to_rtc <= IDX_NONE_W;
            x0_to_rtc  <= '0;
            y0_to_rtc  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rtc_write <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_min_q <= x_min;
                        dx_q    <= dx;
                        dy_q    <= dy;
                        cur_x   <= x_min;
                        cur_y   <= y_max;
                        col     <= '0;
                        row     <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (!rtc_full) begin
                        rtc_write  <= 1'b1;
                        idx_to_rtc <= idx;
                        x0_to_rtc  <= cur_x;
                        y0_to_rtc  <= cur_y;
                        idx        <= idx + 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    wait_cnt <= '0;
                    tgt_y    <= last_col;
                    if (last_col) begin
                        col   <= '0;
                        row   <= row + 1'b1;
                        cur_x <= x_min_q;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_done && add_out_vld) begin
                        if (tgt_y) cur_y <= add_sum;
                        else       cur_x <= add_sum;
                    end
                end
                ST_FINISH: begin
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    idx_to_rtc <= IDX_NONE_W;
                end
                default: ;
            endcase
        end
    end

endmodule
